// File: rtl/gbuff_fetch_skew_pkg.sv
// gbuff_fetch_skew_pkg
// Shared widths and types for the global-buffer fetch/skew block.
// The macro block mirrors the shared define.v: WORD_SIZE and GBUFF_INDX_SIZE
// are the global widths, and LANES/LANE_W describe how a word is split into
// systolic-array lane bytes. The guards let a real define.v compiled earlier
// take precedence.
// Contents:
//   LANES, LANE_W, IDX_W, WORD_W : width constants taken from the macros
//   DRAIN_LAST                   : drain counter start value (5 drain cycles)
//   lane_t                       : one lane byte plus its valid bit
//   idx_next()                   : global-buffer index increment (wraps)

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef GBUFF_INDX_SIZE
`define GBUFF_INDX_SIZE 8
`endif
`ifndef LANES
`define LANES 4
`endif
`ifndef LANE_W
`define LANE_W 8
`endif

package gbuff_fetch_skew_pkg;

  localparam int LANES  = `LANES;
  localparam int LANE_W = `LANE_W;
  localparam int IDX_W  = `GBUFF_INDX_SIZE;
  localparam int WORD_W = `WORD_SIZE;

  // The drain counter runs DRAIN_LAST..0, i.e. five cycles, which is the
  // read latency (1) + capture (1) + the deepest lane skew (3).
  localparam logic [IDX_W-1:0] DRAIN_LAST = IDX_W'(4);

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] data;
  } lane_t;

  // Index arithmetic is modulo 2^IDX_W; the natural overflow of the
  // fixed-width add provides the 255 -> 0 wrap.
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/gbuff_fetch_skew_lane_delay.sv
// lane_delay
// One lane of the skew network. Stage 0 captures the lane byte straight
// from the global-buffer read data; DEPTH further stages delay it so that
// lane i appears i cycles after lane 0. The output byte is forced to zero
// whenever its valid bit is low, giving the systolic array zero padding.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   lane_in    : byte + valid arriving from the read-data path
//   lane_out   : byte + valid after 1 + DEPTH register stages

module lane_delay
  import gbuff_fetch_skew_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  lane_t lane_in,
  output lane_t lane_out
);

  lane_t stage_q [0:DEPTH];
  lane_t stage_d [0:DEPTH];

  always_comb begin
    stage_d[0].valid = lane_in.valid;
    // Only real words enter the line, so idle stages always hold zeros.
    stage_d[0].data  = lane_in.valid ? lane_in.data : '0;
    for (int s = 1; s <= DEPTH; s++) begin
      stage_d[s] = stage_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= DEPTH; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= DEPTH; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  always_comb begin
    lane_out.valid = stage_q[DEPTH].valid;
    lane_out.data  = stage_q[DEPTH].valid ? stage_q[DEPTH].data : '0;
  end

endmodule

// File: rtl/gbuff_fetch_skew.sv
// gbuff_fetch_skew
// Reads len consecutive words from the global buffer starting at base_addr
// and presents them to a systolic array as four byte lanes, lane i delayed
// by i cycles relative to lane 0.
// Request protocol: start is a single-cycle request with no ready/ack. It
// is sampled only while the FSM is IDLE (busy=0, done=0); in any other
// state it is ignored. Completion is signalled by a one-cycle done pulse.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle transfer request
//   base_addr, len      : first index and word count, sampled with start
//   gb_wr_en            : global-buffer write enable, always 0
//   gb_index            : registered global-buffer read index
//   gb_data             : read data, valid one cycle after gb_index
//   row_data, row_valid : skewed lane bytes and their per-lane valids
//   busy, done          : transfer in progress / completion pulse
// Timeline for start accepted in cycle T with len>0:
//   FETCH T+1..T+len, DRAIN T+len+1..T+len+5, DONE T+len+6.

module gbuff_fetch_skew
  import gbuff_fetch_skew_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [`GBUFF_INDX_SIZE-1:0] base_addr,
  input  logic [`GBUFF_INDX_SIZE-1:0] len,
  output logic                        gb_wr_en,
  output logic [`GBUFF_INDX_SIZE-1:0] gb_index,
  input  logic [`WORD_SIZE-1:0]       gb_data,
  output logic [`WORD_SIZE-1:0]       row_data,
  output logic [LANES-1:0]            row_valid,
  output logic                        busy,
  output logic                        done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  // Words still to issue in FETCH; drain cycles remaining in DRAIN.
  logic [IDX_W-1:0] cnt_q,   cnt_d;
  // High in the cycle gb_data carries a word requested the cycle before.
  logic             rd_pend_q, rd_pend_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rd_pend_d = (state_q == ST_FETCH);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = ST_FETCH;
            idx_d   = base_addr;
            cnt_d   = len;
          end else begin
            // Empty transfer: no reads, index untouched, straight to DONE.
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        if (cnt_q == IDX_W'(1)) begin
          // Last index stays on gb_index; it holds until the next transfer.
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
          idx_d = idx_next(idx_q);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign gb_wr_en = 1'b0;
  assign gb_index = idx_q;
  assign busy     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  // Lane i gets byte i of the read word and i extra cycles of delay.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_t lane_in;
    lane_t lane_out;

    always_comb begin
      lane_in.valid = rd_pend_q;
      lane_in.data  = gb_data[i*LANE_W +: LANE_W];
    end

    lane_delay #(
      .DEPTH (i)
    ) u_lane_delay (
      .clk      (clk),
      .rst_n    (rst_n),
      .lane_in  (lane_in),
      .lane_out (lane_out)
    );

    assign row_data[i*LANE_W +: LANE_W] = lane_out.data;
    assign row_valid[i]                 = lane_out.valid;
  end

endmodule

// File: tb/tb_gbuff_fetch_skew.sv
// tb_gbuff_fetch_skew
// Self-checking bench for gbuff_fetch_skew. A behavioural global-buffer
// memory answers reads one cycle after gb_index. Expected outputs for each
// cycle k after start (cycle T+k) come from the transfer timeline: index
// base+k-1 during fetch, word n of lane i visible at k=3+n+i, busy over
// 1..len+5, done at len+6 (or 1 for len=0).

module tb_gbuff_fetch_skew;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  len;
  logic        gb_wr_en;
  logic [7:0]  gb_index;
  logic [31:0] gb_data;
  logic [31:0] row_data;
  logic [3:0]  row_valid;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  idx_hold;
  int          words_out;

  // ---------------- clock / reset / memory ----------------
  always #5 clk = ~clk;

  always @(posedge clk) gb_data <= mem[gb_index];

  gbuff_fetch_skew dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .gb_wr_en  (gb_wr_en),
    .gb_index  (gb_index),
    .gb_data   (gb_data),
    .row_data  (row_data),
    .row_valid (row_valid),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_index(input logic [7:0] b, input logic [7:0] l,
                                             input int k, input logic [7:0] hold);
    if (l == 8'd0 || k < 1) return hold;
    if (k <= int'(l)) return 8'((int'(b) + k - 1) & 255);
    return 8'((int'(b) + int'(l) - 1) & 255);
  endfunction

  task automatic model_row(input logic [7:0] b, input logic [7:0] l, input int k,
                           output logic [31:0] er, output logic [3:0] ev);
    logic [31:0] w;
    er = '0;
    ev = '0;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = k - 3 - i;
      if (n >= 0 && n < int'(l)) begin
        w = mem[(int'(b) + n) & 255];
        ev[i] = 1'b1;
        er[8*i +: 8] = w[8*i +: 8];
      end
    end
  endtask

  // ---------------- driver + per-cycle checker ----------------
  // Entered and left at posedge+1. restart_k >= 1 pulses a spurious start
  // with random parameters in that cycle; it must have no effect.
  task automatic run_xfer(input logic [7:0] b, input logic [7:0] l, input int restart_k,
                          input string name);
    int          last;
    logic [7:0]  ei;
    logic [31:0] er;
    logic [3:0]  ev;
    logic        eb, ed;
    last = (l == 8'd0) ? 1 : int'(l) + 6;
    words_out = 0;
    for (int k = 0; k <= last; k++) begin
      if (k == 0) begin
        start = 1'b1; base_addr = b; len = l;
      end else if (k == restart_k) begin
        start = 1'b1;
        base_addr = 8'($urandom);
        len = 8'($urandom_range(1, 255));
      end else begin
        start = 1'b0;
        base_addr = 8'($urandom);
        len = 8'($urandom);
      end
      @(negedge clk);
      ei = model_index(b, l, k, idx_hold);
      model_row(b, l, k, er, ev);
      eb = (l != 8'd0) && (k >= 1) && (k <= int'(l) + 5);
      ed = (k == last);
      checks++;
      if (gb_index !== ei) begin
        errors++;
        $display("FAIL %s gb_index k=%0d: got %0d expected %0d", name, k, gb_index, ei);
      end
      checks++;
      if (row_valid !== ev) begin
        errors++;
        $display("FAIL %s row_valid k=%0d: got %b expected %b", name, k, row_valid, ev);
      end
      checks++;
      if (row_data !== er) begin
        errors++;
        $display("FAIL %s row_data k=%0d: got %h expected %h", name, k, row_data, er);
      end
      checks++;
      if (busy !== eb || done !== ed) begin
        errors++;
        $display("FAIL %s busy/done k=%0d: got %b/%b expected %b/%b", name, k, busy, done, eb, ed);
      end
      checks++;
      if (gb_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL %s gb_wr_en k=%0d: got %b expected 0", name, k, gb_wr_en);
      end
      if (row_valid[3] === 1'b1) words_out++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (l != 8'd0) idx_hold = 8'((int'(b) + int'(l) - 1) & 255);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (gb_index !== 8'd0 || row_data !== 32'd0 || row_valid !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0 || gb_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got idx=%0d row=%h v=%b busy=%b done=%b we=%b expected all 0",
               gb_index, row_data, row_valid, busy, done, gb_wr_en);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idx_hold = 8'd0;
  endtask

  task automatic test_basic();
    for (int a = 0; a < 256; a++) mem[a] = a * 32'h01010101;
    // First start lands in the first cycle after reset release.
    run_xfer(8'd4, 8'd3, -1, "basic");
    checks++;
    if (words_out != 3) begin
      errors++;
      $display("FAIL basic_words: got %0d expected 3", words_out);
    end
  endtask

  task automatic test_wrap();
    fill_random();
    run_xfer(8'd254, 8'd4, -1, "wrap");
    run_xfer(8'd255, 8'd1, -1, "wrap1");
  endtask

  task automatic test_len_zero();
    run_xfer(8'd77, 8'd0, -1, "len0");
  endtask

  task automatic test_ignore_start();
    int d;
    run_xfer(8'd20, 8'd8, 2, "ignore_fetch");
    checks++;
    if (words_out != 8) begin
      errors++;
      $display("FAIL ignore_words: got %0d expected 8", words_out);
    end
    d = 8 + 6;
    run_xfer(8'd100, 8'd5, 8, "ignore_drain");
    run_xfer(8'd30, 8'd2, d - 6, "ignore_done");
  endtask

  task automatic test_reset_mid();
    start = 1'b1; base_addr = 8'd40; len = 8'd8;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (gb_index !== 8'd0 || row_data !== 32'd0 || row_valid !== 4'd0 ||
        busy !== 1'b0 || done !== 1'b0 || gb_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got idx=%0d row=%h v=%b busy=%b done=%b expected all 0",
               gb_index, row_data, row_valid, busy, done);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    idx_hold = 8'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || row_valid !== 4'd0 || gb_index !== 8'd0) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d: got done=%b busy=%b v=%b idx=%0d expected 0",
                 k, done, busy, row_valid, gb_index);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_xfer(8'd10, 8'd6, -1, "b2b_first");
    run_xfer(8'd200, 8'd9, -1, "b2b_second");
  endtask

  task automatic test_random();
    fill_random();
    for (int t = 0; t < 8; t++) begin
      logic [7:0] b, l;
      int rk;
      b = 8'($urandom);
      l = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      rk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, int'(l) + 6) : -1;
      if (l == 8'd0) rk = 1;
      run_xfer(b, l, rk, "random");
    end
    run_xfer(8'($urandom), 8'd255, -1, "full_len");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbuff_fetch_skew.md
GBUFF_FETCH_SKEW -- requirements
Module: gbuff_fetch_skew

Interface
REQ-001 SHALL take all widths from the shared define.v macros: `WORD_SIZE (32) and `GBUFF_INDX_SIZE (8); no module parameters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 base_addr  input  `GBUFF_INDX_SIZE  first global-buffer index to read; sampled with start.
REQ-006 len  input  `GBUFF_INDX_SIZE  number of words to fetch (0..255); sampled with start.
REQ-007 gb_wr_en  output  1  write enable to the global buffer; this block is read-only, constant 0.
REQ-008 gb_index  output  `GBUFF_INDX_SIZE  registered read index to the global buffer.
REQ-009 gb_data  input  `WORD_SIZE  global-buffer read data; valid one cycle after gb_index is presented.
REQ-010 row_data  output  `WORD_SIZE  skewed lane bytes; lane i = bits [8i+7:8i], i=0..3.
REQ-011 row_valid  output  4  per-lane valid; bit i qualifies lane i of row_data.
REQ-012 busy  output  1  high from the cycle after start acceptance until the last lane-3 output.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL use FSM states IDLE, FETCH, DRAIN, DONE; DONE returns to IDLE after one cycle.
REQ-015 start in IDLE at cycle T SHALL latch base_addr/len; next state FETCH if len!=0, else DONE.
REQ-016 In FETCH, gb_index SHALL equal base_addr+n during cycle T+1+n, n=0..len-1; FETCH lasts exactly len cycles.
REQ-017 Index arithmetic SHALL be modulo 2^`GBUFF_INDX_SIZE: 255 wraps to 0.
REQ-018 A one-bit read-pending pipeline SHALL track which cycles of gb_data carry valid words (word n at T+2+n).
REQ-019 Word n SHALL be captured into a lane-0 stage; lane i byte SHALL appear on row_data with row_valid[i]=1 during cycle T+3+n+i.
REQ-020 Lanes whose row_valid bit is 0 SHALL drive 8'h00 (zero padding for the systolic array).
REQ-021 DRAIN SHALL last exactly 5 cycles (T+len+1..T+len+5); DONE (done=1, busy=0) SHALL occur in cycle T+len+6.
REQ-022 len=0: no reads, no row_valid, busy stays 0, done=1 in cycle T+1.
REQ-023 start while not in IDLE (FETCH, DRAIN, DONE) SHALL be ignored, with no effect on the running transfer.
REQ-024 gb_index SHALL hold its last value outside FETCH; gb_wr_en SHALL be 0 in every cycle, including reset.
REQ-025 Back-to-back operation: start in the IDLE cycle directly after DONE SHALL be accepted normally.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, gb_index=0, row_data=0, row_valid=0, busy=0, done=0, and clear all pipeline/skew registers.
REQ-027 Reset mid-transfer SHALL abandon the transfer; no done pulse and no residual row_valid after release.
REQ-028 First start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-029 Constants LANES=4 and LANE_W=8 SHALL be added to define.v; FSM state encodings stay local.
REQ-030 The per-lane delay line SHALL be one sub-module, lane_delay (depth parameterised 0..3, carries byte+valid), instantiated four times.

Verification
REQ-031 Gbuff preloaded word[k]=k*32'h01010101, start with base=4, len=3 -> gb_index 4,5,6 in T+1..T+3; lane0 bytes 04,05,06 at T+3..T+5; lane3 bytes 04,05,06 at T+6..T+8; done at T+9.
REQ-032 base=254, len=4 -> gb_index 254,255,0,1; data order follows wrapped indices.
REQ-033 len=0 -> done at T+1, busy never high, row_valid stays 0, no index change.
REQ-034 start pulsed again at T+2 of a len=8 transfer -> ignored; exactly 8 words out and one done at T+14.
REQ-035 rst_n low at T+4 of a len=8 transfer -> all outputs 0 asynchronously; after release no done, row_valid 0 until the next start.
REQ-036 Two transfers back-to-back (second start in the IDLE cycle after DONE) -> both complete with correct data and two done pulses; gb_wr_en 0 throughout.
